// File: rtl/cla_multiword_seq_pkg.sv
// Shared definitions for the sequential multi-word CLA adder/subtractor:
// limb width, FSM state encoding and the limb-select helper.
package cla_multiword_seq_pkg;

  localparam int LIMB_W    = 16;
  localparam int MAX_WORDS = 8;
  localparam int MAX_DW    = LIMB_W * MAX_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Callers zero-extend narrower vectors to MAX_DW before selecting a limb.
  function automatic logic [LIMB_W-1:0] limb_sel(input logic [MAX_DW-1:0] vec,
                                                 input logic [2:0]        idx);
    limb_sel = vec[idx*LIMB_W +: LIMB_W];
  endfunction

endpackage

// File: rtl/cla_multiword_seq_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with the group
// carry rippled between them. Purely combinational.
module CLA_16bit_ripple (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Lookahead carries inside each group, group carry-out feeds the next group
  always_comb begin
    logic [16:0] v_c;
    logic [3:0]  v_gen;
    logic [3:0]  v_pr;
    logic        v_cg;
    v_c    = 17'd0;
    v_c[0] = i_cin;
    for (int g = 0; g < 4; g++) begin
      v_gen = w_g[4*g +: 4];
      v_pr  = w_p[4*g +: 4];
      v_cg  = v_c[4*g];
      v_c[4*g+1] = v_gen[0] | (v_pr[0] & v_cg);
      v_c[4*g+2] = v_gen[1] | (v_pr[1] & v_gen[0]) | (v_pr[1] & v_pr[0] & v_cg);
      v_c[4*g+3] = v_gen[2] | (v_pr[2] & v_gen[1]) | (v_pr[2] & v_pr[1] & v_gen[0])
                 | (v_pr[2] & v_pr[1] & v_pr[0] & v_cg);
      v_c[4*g+4] = v_gen[3] | (v_pr[3] & v_gen[2]) | (v_pr[3] & v_pr[2] & v_gen[1])
                 | (v_pr[3] & v_pr[2] & v_pr[1] & v_gen[0]) | ((&v_pr) & v_cg);
    end
    o_sum  = w_p ^ v_c[15:0];
    o_cout = v_c[16];
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// Sequential multi-precision add/sub: one 16-bit CLA slice processes one limb
// per cycle, LSB first, with the carry registered between limbs.
module cla_multiword_seq
  import cla_multiword_seq_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int DW    = LIMB_W * WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_sub,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sum,
  output logic          out_cout,
  output logic          out_ovf,
  output logic          busy
);

  localparam int IDX_W = $clog2(WORDS);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [DW-1:0]      r_a;
  logic [DW-1:0]      r_b;
  logic [DW-1:0]      r_sum;
  logic [DW-1:0]      r_out_sum;
  logic               r_out_cout;
  logic               r_out_ovf;
  logic [LIMB_W-1:0]  w_a_limb;
  logic [LIMB_W-1:0]  w_b_limb;
  logic [LIMB_W-1:0]  w_slice_sum;
  logic               w_slice_cout;
  logic               w_accept;
  logic               w_last;

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDX_W'(WORDS - 1));
  assign w_a_limb = limb_sel(MAX_DW'(r_a), 3'(r_idx));
  assign w_b_limb = limb_sel(MAX_DW'(r_b), 3'(r_idx));

  CLA_16bit_ripple u_slice (
    .i_a    (w_a_limb),
    .i_b    (w_b_limb),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_RUN;
        else          w_next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_next_state = ST_DONE;
        else        w_next_state = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) w_next_state = ST_IDLE;
        else           w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on capture and carry seeded with in_sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b ^ {DW{in_sub}};
            r_carry <= in_sub;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[r_idx*LIMB_W +: LIMB_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_out_sum  <= {w_slice_sum, r_sum[DW-LIMB_W-1:0]};
            r_out_cout <= w_slice_cout;
            r_out_ovf  <= (r_a[DW-1] == r_b[DW-1]) && (w_slice_sum[LIMB_W-1] != r_a[DW-1]);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed self-checking bench for cla_multiword_seq with WORDS=4 (64-bit).
module tb_cla_multiword_seq;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  cla_multiword_seq #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE, wait for out_valid (bounded), capture, then hand off.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                        output logic [DW-1:0] s, output logic c, output logic o,
                        output int lat);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = out_sum; c = out_cout; o = out_ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during_rst got %0b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, out_cout, out_ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {out_valid, busy, out_cout, out_ovf});
    end
    checks++;
    if (out_sum !== 64'h0) begin errors++; $display("FAIL reset_sum got %h want 0", out_sum); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic check_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sub, input logic [DW-1:0] es, input logic ec, input logic eo);
    logic [DW-1:0] s;
    logic c, o;
    int lat;
    run_op(a, b, sub, s, c, o, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL %s_latency got %0d want 4", name, lat); end
    checks++;
    if (s !== es) begin errors++; $display("FAIL %s_sum got %h want %h", name, s, es); end
    checks++;
    if ({c, o} !== {ec, eo}) begin errors++; $display("FAIL %s_cout_ovf got %b want %b", name, {c, o}, {ec, eo}); end
  endtask

  task automatic test_add();
    check_op("add_limb_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    check_op("add_full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    check_op("add_overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    check_op("sub_5_7", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    check_op("sub_7_5", 64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0);
    check_op("sub_min_1", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    in_a = 64'h1111; in_b = 64'h2222; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 64'h10; in_b = 64'h20;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_first_latency got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, busy, out_cout, out_ovf} !== 5'b10100 || out_sum !== 64'h3333) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%0b r=%0b b=%0b sum=%h want v=1 r=0 b=1 sum=3333",
                 i, out_valid, in_ready, busy, out_sum);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010 || out_sum !== 64'h3333) begin
      errors++;
      $display("FAIL bp_release got v=%0b r=%0b b=%0b sum=%h want v=0 r=1 b=0 sum=3333",
               out_valid, in_ready, busy, out_sum);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 4 || out_sum !== 64'h30) begin
      errors++; $display("FAIL bp_held_request got lat=%0d sum=%h want lat=4 sum=30", lat, out_sum);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, out_cout, out_ovf} !== 5'b00100 || out_sum !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset got v=%0b b=%0b r=%0b c=%0b o=%0b sum=%h want v=0 b=0 r=1 c=0 o=0 sum=0",
               out_valid, busy, in_ready, out_cout, out_ovf, out_sum);
    end
    check_op("after_reset", 64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
